// File: rtl/stream_format_checker.sv
// Parses ';'-terminated decimal, hex (0x) and binary (0b) tokens one character
// per cycle and reports the token format, an error code and the parsed value.
module stream_format_checker #(
  parameter int VAL_W   = 32,
  parameter int MAX_LEN = 16,
  parameter int TO_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char,
  input  logic             char_valid,
  input  logic [TO_W-1:0]  freq,
  output logic             done,
  output logic [1:0]       format_type,
  output logic [3:0]       error_code,
  output logic [VAL_W-1:0] value
);

  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int WIDE_W = VAL_W + 4;

  localparam logic [1:0] F_NONE = 2'b00;
  localparam logic [1:0] F_DEC  = 2'b01;
  localparam logic [1:0] F_HEX  = 2'b10;
  localparam logic [1:0] F_BIN  = 2'b11;

  localparam logic [3:0] E_OK      = 4'd0;
  localparam logic [3:0] E_EMPTY   = 4'd1;
  localparam logic [3:0] E_ILLEGAL = 4'd2;
  localparam logic [3:0] E_OVF     = 4'd3;
  localparam logic [3:0] E_TIMEOUT = 4'd4;
  localparam logic [3:0] E_LONG    = 4'd5;
  localparam logic [3:0] E_PREFIX  = 4'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_ZERO, S_DEC, S_HEXP, S_HEX, S_BINP, S_BIN, S_ERR
  } state_t;

  state_t            state_reg, state_next;
  logic [VAL_W-1:0]  acc_reg, acc_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic [3:0]        code_reg, code_next;
  logic [TO_W-1:0]   cnt_reg, cnt_next;
  logic              done_reg, done_next;
  logic [1:0]        fmt_reg, fmt_next;
  logic [3:0]        err_reg, err_next;
  logic [VAL_W-1:0]  val_reg, val_next;

  logic              is_dec, is_hex, is_bin, is_x, is_b, is_term;
  logic [3:0]        dig;
  logic              take;
  logic [4:0]        base;
  state_t            dig_state;
  logic [WIDE_W-1:0] wide;
  logic              ovf;
  logic [1:0]        res_fmt;
  logic [3:0]        res_err;
  logic              fault;
  logic [3:0]        fault_code;

  always_comb begin
    is_dec  = (char >= 8'h30) && (char <= 8'h39);
    is_bin  = (char == 8'h30) || (char == 8'h31);
    is_x    = (char == 8'h78) || (char == 8'h58);
    is_b    = (char == 8'h62) || (char == 8'h42);
    is_term = (char == 8'h3b);
    is_hex  = is_dec;
    dig     = 4'd0;
    if (is_dec) begin
      dig = 4'(char - 8'h30);
    end else if ((char >= 8'h61) && (char <= 8'h66)) begin
      is_hex = 1'b1;
      dig    = 4'(char - 8'h57);
    end else if ((char >= 8'h41) && (char <= 8'h46)) begin
      is_hex = 1'b1;
      dig    = 4'(char - 8'h37);
    end
  end

  // Which digits each state accepts, in which base, and where they lead.
  // IDLE/ZERO always hold acc == 0, so they share the base-10 datapath.
  always_comb begin
    take      = 1'b0;
    base      = 5'd10;
    dig_state = state_reg;
    case (state_reg)
      S_IDLE: if (is_dec) begin
        take      = 1'b1;
        dig_state = (dig == 4'd0) ? S_ZERO : S_DEC;
      end
      S_ZERO, S_DEC: if (is_dec) begin
        take      = 1'b1;
        dig_state = S_DEC;
      end
      S_HEXP, S_HEX: if (is_hex) begin
        take      = 1'b1;
        base      = 5'd16;
        dig_state = S_HEX;
      end
      S_BINP, S_BIN: if (is_bin) begin
        take      = 1'b1;
        base      = 5'd2;
        dig_state = S_BIN;
      end
      default: ;
    endcase
  end

  assign wide = {4'b0000, acc_reg} * WIDE_W'(base) + WIDE_W'(dig);
  assign ovf  = |wide[WIDE_W-1:VAL_W];

  always_comb begin
    res_fmt = F_NONE;
    res_err = E_OK;
    case (state_reg)
      S_IDLE:         res_err = E_EMPTY;
      S_ZERO, S_DEC:  res_fmt = F_DEC;
      S_HEX:          res_fmt = F_HEX;
      S_BIN:          res_fmt = F_BIN;
      S_HEXP, S_BINP: res_err = E_PREFIX;
      default:        res_err = code_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    len_next   = len_reg;
    code_next  = code_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    fmt_next   = fmt_reg;
    err_next   = err_reg;
    val_next   = val_reg;
    fault      = 1'b0;
    fault_code = E_OK;
    if (char_valid) begin
      cnt_next = '0;
      if (is_term) begin
        done_next  = 1'b1;
        fmt_next   = res_fmt;
        err_next   = res_err;
        val_next   = (res_err == E_OK) ? acc_reg : '0;
        state_next = S_IDLE;
        acc_next   = '0;
        len_next   = '0;
        code_next  = E_OK;
      end else if (state_reg != S_ERR) begin
        len_next = (len_reg == LEN_W'(MAX_LEN)) ? len_reg : len_reg + 1'b1;
        if (take) begin
          if (ovf) begin
            fault      = 1'b1;
            fault_code = E_OVF;
          end else begin
            state_next = dig_state;
            acc_next   = wide[VAL_W-1:0];
          end
        end else if ((state_reg == S_ZERO) && is_x) begin
          state_next = S_HEXP;
        end else if ((state_reg == S_ZERO) && is_b) begin
          state_next = S_BINP;
        end else begin
          fault      = 1'b1;
          fault_code = E_ILLEGAL;
        end
        // A character arriving with MAX_LEN already counted is one too many.
        if (!fault && (len_reg == LEN_W'(MAX_LEN))) begin
          fault      = 1'b1;
          fault_code = E_LONG;
        end
        if (fault) begin
          state_next = S_ERR;
          code_next  = fault_code;
          acc_next   = '0;
        end
      end
    end else if (state_reg != S_IDLE) begin
      if ((freq != '0) && (cnt_reg >= freq - 1'b1)) begin
        done_next  = 1'b1;
        fmt_next   = F_NONE;
        err_next   = E_TIMEOUT;
        val_next   = '0;
        state_next = S_IDLE;
        acc_next   = '0;
        len_next   = '0;
        code_next  = E_OK;
        cnt_next   = '0;
      end else if (cnt_reg != '1) begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      acc_reg   <= '0;
      len_reg   <= '0;
      code_reg  <= E_OK;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      fmt_reg   <= F_NONE;
      err_reg   <= E_OK;
      val_reg   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      len_reg   <= len_next;
      code_reg  <= code_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      fmt_reg   <= fmt_next;
      err_reg   <= err_next;
      val_reg   <= val_next;
    end
  end

  assign done        = done_reg;
  assign format_type = fmt_reg;
  assign error_code  = err_reg;
  assign value       = val_reg;

endmodule

// File: tb/tb_stream_format_checker.sv
// Bench for stream_format_checker: three parameterisations share one character
// stream; expected results are queued when ';' is driven and checked on done.
module tb_stream_format_checker;
  localparam int TO_W = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0]      char;
  logic            char_valid;
  logic [TO_W-1:0] freq;
  logic [2:0]        done_v;
  logic [2:0][1:0]   fmt_v;
  logic [2:0][3:0]   err_v;
  logic [2:0][31:0]  val_v;
  logic [7:0]        val1;

  always #5 clk = ~clk;

  stream_format_checker #(.VAL_W(32), .MAX_LEN(16), .TO_W(TO_W)) dut (
    .clk(clk), .reset(reset), .char(char), .char_valid(char_valid), .freq(freq),
    .done(done_v[0]), .format_type(fmt_v[0]), .error_code(err_v[0]), .value(val_v[0]));
  stream_format_checker #(.VAL_W(8), .MAX_LEN(16), .TO_W(TO_W)) dut_v8 (
    .clk(clk), .reset(reset), .char(char), .char_valid(char_valid), .freq(freq),
    .done(done_v[1]), .format_type(fmt_v[1]), .error_code(err_v[1]), .value(val1));
  stream_format_checker #(.VAL_W(32), .MAX_LEN(4), .TO_W(TO_W)) dut_l4 (
    .clk(clk), .reset(reset), .char(char), .char_valid(char_valid), .freq(freq),
    .done(done_v[2]), .format_type(fmt_v[2]), .error_code(err_v[2]), .value(val_v[2]));
  assign val_v[1] = {24'd0, val1};

  typedef struct packed { logic [1:0] fmt; logic [3:0] err; logic [31:0] val; } res_t;
  typedef struct { string tok; res_t r0; res_t r1; res_t r2; } vec_t;
  typedef struct { int cyc; string tok; res_t r0; res_t r1; res_t r2; } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t mk(input logic [1:0] f, input logic [3:0] e, input logic [31:0] v);
    res_t r;
    r.fmt = f; r.err = e; r.val = v;
    return r;
  endfunction

  task automatic add(input string t, input res_t a, input res_t b, input res_t c);
    vec_t v;
    v.tok = t; v.r0 = a; v.r1 = b; v.r2 = c;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string t, input res_t a, input res_t b, input res_t c, input int at);
    exp_t e;
    e.cyc = at; e.tok = t; e.r0 = a; e.r1 = b; e.r2 = c;
    sb.push_back(e);
  endtask

  task automatic res_chk(input int i, input string t, input res_t r);
    check($sformatf("dut%0d '%s' done", i, t), 32'(done_v[i]), 32'd1);
    check($sformatf("dut%0d '%s' fmt", i, t), 32'(fmt_v[i]), 32'(r.fmt));
    check($sformatf("dut%0d '%s' err", i, t), 32'(err_v[i]), 32'(r.err));
    check($sformatf("dut%0d '%s' val", i, t), val_v[i], r.val);
  endtask

  // Scoreboard: an expected result must appear exactly on its cycle, and done
  // must stay low on every other cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        cur = sb.pop_front();
        res_chk(0, cur.tok, cur.r0);
        res_chk(1, cur.tok, cur.r1);
        res_chk(2, cur.tok, cur.r2);
        $display("token '%s' cycle %0d: fmt=%0d/%0d/%0d err=%0d/%0d/%0d val=%0d/%0d/%0d",
                 cur.tok, cyc, fmt_v[0], fmt_v[1], fmt_v[2], err_v[0], err_v[1], err_v[2],
                 val_v[0], val_v[1], val_v[2]);
      end else begin
        check($sformatf("no_done cycle %0d", cyc), 32'(done_v), 32'd0);
      end
    end
  end

  task automatic drive(input logic [7:0] c, input logic v);
    char = c;
    char_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(8'h00, 1'b0);
  endtask

  task automatic send_token(input string t, input res_t a, input res_t b, input res_t c,
                            input bit stalls);
    for (int i = 0; i < t.len(); i++) begin
      if (stalls) idle(int'($urandom_range(0, 2)));
      if (t[i] == 8'h3b) push_exp(t, a, b, c, cyc + 1);
      drive(t[i], 1'b1);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s dut%0d done", tag, i), 32'(done_v[i]), 32'd0);
      check($sformatf("%s dut%0d fmt", tag, i), 32'(fmt_v[i]), 32'd0);
      check($sformatf("%s dut%0d err", tag, i), 32'(err_v[i]), 32'd0);
      check($sformatf("%s dut%0d val", tag, i), val_v[i], 32'd0);
    end
  endtask

  initial begin
    res_t e_ok0, e1, e2, e3, e4, e5, e6;
    e1 = mk(2'd0, 4'd1, 32'd0);
    e2 = mk(2'd0, 4'd2, 32'd0);
    e3 = mk(2'd0, 4'd3, 32'd0);
    e4 = mk(2'd0, 4'd4, 32'd0);
    e5 = mk(2'd0, 4'd5, 32'd0);
    e6 = mk(2'd0, 4'd6, 32'd0);
    e_ok0 = mk(2'd1, 4'd0, 32'd0);

    //   token                       VAL_W=32,MAX_LEN=16         VAL_W=8                   MAX_LEN=4
    add("255;",                    mk(1, 0, 255),              mk(1, 0, 255),            mk(1, 0, 255));
    add("0x1F;",                   mk(2, 0, 31),               mk(2, 0, 31),             mk(2, 0, 31));
    add("0b101;",                  mk(3, 0, 5),                mk(3, 0, 5),              e5);
    add(";",                       e1,                         e1,                       e1);
    add("0x;",                     e6,                         e6,                       e6);
    add("0b;",                     e6,                         e6,                       e6);
    add("1a2;",                    e2,                         e2,                       e2);
    add("0b12;",                   e2,                         e2,                       e2);
    add("x;",                      e2,                         e2,                       e2);
    add("1x;",                     e2,                         e2,                       e2);
    add("256;",                    mk(1, 0, 256),              e3,                       mk(1, 0, 256));
    add("12345;",                  mk(1, 0, 12345),            e3,                       e5);
    add("0;",                      e_ok0,                      e_ok0,                    e_ok0);
    add("07;",                     mk(1, 0, 7),                mk(1, 0, 7),              mk(1, 0, 7));
    add("0XfF;",                   mk(2, 0, 255),              mk(2, 0, 255),            mk(2, 0, 255));
    add("0xFFFFFFFF;",             mk(2, 0, 32'hFFFFFFFF),     e3,                       e5);
    add("0x100000000;",            e3,                         e3,                       e5);
    add("4294967295;",             mk(1, 0, 32'hFFFFFFFF),     e3,                       e5);
    add("4294967296;",             e3,                         e3,                       e5);
    add("0000000000000001;",       mk(1, 0, 1),                mk(1, 0, 1),              e5);
    add("00000000000000001;",      e5,                         e5,                       e5);
    add("0b11111111;",             mk(3, 0, 255),              mk(3, 0, 255),            e5);
    add("0b111111111;",            mk(3, 0, 511),              e3,                       e5);
    add("9g9999999999999999999;",  e2,                         e2,                       e2);

    reset = 1'b1; char = 8'h00; char_valid = 1'b0; freq = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;
    idle(2);

    foreach (vecs[i]) send_token(vecs[i].tok, vecs[i].r0, vecs[i].r1, vecs[i].r2, 1'b1);
    idle(3);

    // Timeout: '7' then three idle cycles with freq=3.
    freq = 16'd3;
    push_exp("7<timeout>", e4, e4, e4, cyc + 4);
    drive(8'h37, 1'b1);
    idle(5);

    // A char on the would-be timeout cycle wins and restarts the count.
    drive(8'h37, 1'b1);
    idle(2);
    drive(8'h38, 1'b1);
    push_exp("78;", mk(1, 0, 78), mk(1, 0, 78), mk(1, 0, 78), cyc + 1);
    drive(8'h3b, 1'b1);
    idle(2);

    // Lowering freq mid-token takes effect on the very next idle cycle.
    freq = 16'd100;
    drive(8'h35, 1'b1);
    idle(5);
    freq = 16'd2;
    push_exp("5<freq lowered>", e4, e4, e4, cyc + 1);
    idle(3);

    // freq=0 disables the timeout entirely.
    freq = '0;
    drive(8'h37, 1'b1);
    idle(1000);
    push_exp("7;", mk(1, 0, 7), mk(1, 0, 7), mk(1, 0, 7), cyc + 1);
    drive(8'h3b, 1'b1);
    idle(4);
    check("hold fmt", 32'(fmt_v[0]), 32'd1);
    check("hold val", val_v[0], 32'd7);

    // Reset in the middle of "0x1" abandons the token with no done.
    drive(8'h30, 1'b1);
    drive(8'h78, 1'b1);
    drive(8'h31, 1'b1);
    reset = 1'b1;
    #1;
    chk_zero("mid_reset");
    idle(2);
    chk_zero("mid_reset_hold");
    reset = 1'b0;
    idle(1);
    send_token("9;", mk(1, 0, 9), mk(1, 0, 9), mk(1, 0, 9), 1'b0);
    idle(3);

    check("pending results", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
